// File: rtl/int_log_pkg.sv
// int_log_pkg: shared opcodes, FSM states and data width for the logic unit controller
package int_log_pkg;
    localparam int DW = 64;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/int_log_fifo.sv
// int_log_fifo: command FIFO with wrapping pointers and occupancy count
module int_log_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   din,
    output logic [W-1:0]                   dout,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign count = count_q;
endmodule

// File: rtl/int_log_ctrl.sv
// int_log_ctrl: queues tagged logic commands, issues them to the logic unit and returns tagged results
module int_log_ctrl
    import int_log_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT = 1,
    parameter int TAGW = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [DW-1:0]              cmd_opa,
    input  logic [DW-1:0]              cmd_opb,
    input  logic [TAGW-1:0]            cmd_tag,
    output logic [2:0]                 log_op,
    output logic [DW-1:0]              log_opa,
    output logic [DW-1:0]              log_opb,
    input  logic [DW-1:0]              log_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DW-1:0]              rsp_data,
    output logic [TAGW-1:0]            rsp_tag,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int CNTW = $clog2(LAT+1);
    localparam int FW = 3 + 2*DW + TAGW;
    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d, data_q, data_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d, push, pop;
    logic [FW-1:0]   head;
    assign cmd_ready = fifo_count < CW'(DEPTH);
    assign push = cmd_valid && cmd_ready;
    int_log_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({cmd_op, cmd_opa, cmd_opb, cmd_tag}),
        .dout  (head),
        .count (fifo_count)
    );
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (fifo_count != '0) begin
                pop = 1'b1;
                {op_d, opa_d, opb_d, tag_d} = head;
                state_d = ISSUE;
            end
            ISSUE: if (op_q == OP_ILL) begin
                data_d  = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d   = CNTW'(LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    data_d  = log_out;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    assign log_op    = op_q;
    assign log_opa   = opa_q;
    assign log_opb   = opb_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_data  = data_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_int_log_ctrl.sv
// tb_int_log_ctrl: directed checks of int_log_ctrl at LAT=1, plus a LAT=4 copy for mid-WAIT reset
module tb_int_log_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, rsp_ready;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_opa, cmd_opb;
    logic [3:0]  cmd_tag;
    logic        cmd_ready, rsp_valid, rsp_err, busy;
    logic [2:0]  log_op;
    logic [63:0] log_opa, log_opb, log_out, rsp_data;
    logic [3:0]  rsp_tag;
    logic [2:0]  fifo_count;
    logic        cmd_ready4, rsp_valid4, rsp_err4, busy4;
    logic [2:0]  log_op4;
    logic [63:0] log_opa4, log_opb4, log_out4, rsp_data4;
    logic [3:0]  rsp_tag4;
    logic [2:0]  fifo_count4;
    int errs = 0;
    int checks = 0;
    logic watch = 1'b0;
    logic seen4 = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [63:0] lu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'b000: return a & b;
            3'b001: return ~(a & b);
            3'b010: return a | b;
            3'b011: return ~(a | b);
            3'b100: return a ^ b;
            3'b101: return ~(a ^ b);
            3'b110: return (a == 64'h0) ? 64'h1 : 64'h0;
            default: return 64'h0;
        endcase
    endfunction
    assign log_out  = lu(log_op, log_opa, log_opb);
    assign log_out4 = lu(log_op4, log_opa4, log_opb4);
    int_log_ctrl #(.DEPTH(4), .LAT(1), .TAGW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_tag(cmd_tag),
        .log_op(log_op), .log_opa(log_opa), .log_opb(log_opb), .log_out(log_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy), .fifo_count(fifo_count)
    );
    int_log_ctrl #(.DEPTH(4), .LAT(4), .TAGW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_tag(cmd_tag),
        .log_op(log_op4), .log_opa(log_opa4), .log_opb(log_opb4), .log_out(log_out4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_data(rsp_data4),
        .rsp_tag(rsp_tag4), .rsp_err(rsp_err4), .busy(busy4), .fifo_count(fifo_count4)
    );
    always @(negedge clk) if (watch && rsp_valid4) seen4 <= 1'b1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        cmd_op = op; cmd_opa = a; cmd_opb = b; cmd_tag = tag; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask
    task automatic expect_rsp(input string tag, input int lat, input logic [63:0] data, input logic [3:0] t, input logic err);
        int k = 0;
        while (!rsp_valid && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(lat));
        chk({tag, "_data"}, rsp_data, data);
        chk({tag, "_tag"}, 64'(rsp_tag), 64'(t));
        chk({tag, "_err"}, 64'(rsp_err), 64'(err));
        step();
    endtask
    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_opa = '0; cmd_opb = '0; cmd_tag = '0;
        #3;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_count", 64'(fifo_count), 64'h0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        #9 rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        push(3'b000, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 4'd3);
        expect_rsp("and", 3, 64'h0F000F000F000F00, 4'd3, 1'b0);
        chk("and_idle", 64'(busy), 64'h0);
        chk("and_log_opa_hold", log_opa, 64'hFF00FF00FF00FF00);
        push(3'b110, 64'h0, 64'h0, 4'd1);
        expect_rsp("not0", 3, 64'h1, 4'd1, 1'b0);
        push(3'b110, 64'h5, 64'h0, 4'd2);
        expect_rsp("not5", 3, 64'h0, 4'd2, 1'b0);
        push(3'b111, 64'd123, 64'd456, 4'd9);
        expect_rsp("ill", 2, 64'h0, 4'd9, 1'b1);
        push(3'b010, 64'hF0, 64'h0F, 4'd5);
        expect_rsp("or", 3, 64'hFF, 4'd5, 1'b0);
        push(3'b100, 64'hFFFF0000FFFF0000, 64'hFF00FF00FF00FF00, 4'd6);
        expect_rsp("xor", 3, 64'h00FFFF0000FFFF00, 4'd6, 1'b0);
        rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) push(3'b010, 64'hA0 + 64'(t), 64'(t) << 8, 4'(t));
        chk("full_ready", 64'(cmd_ready), 64'h0);
        chk("full_count", 64'(fifo_count), 64'h4);
        push(3'b000, 64'h1, 64'h1, 4'd15);
        chk("full_count_hold", 64'(fifo_count), 64'h4);
        chk("bp_valid", 64'(rsp_valid), 64'h1);
        chk("bp_data0", rsp_data, 64'hA0);
        step();
        step();
        chk("bp_valid_hold", 64'(rsp_valid), 64'h1);
        chk("bp_data_hold", rsp_data, 64'hA0);
        chk("bp_tag_hold", 64'(rsp_tag), 64'h0);
        rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++)
            expect_rsp($sformatf("bp%0d", t), t == 0 ? 0 : 3, 64'hA0 + 64'(t) + (64'(t) << 8), 4'(t), 1'b0);
        chk("bp_empty", 64'(busy), 64'h0);
        rsp_ready = 1'b0;
        push(3'b000, 64'hFFFFFFFFFFFFFFFF, 64'h11, 4'd1);
        push(3'b001, 64'hF0, 64'hFF, 4'd2);
        push(3'b101, 64'hFF, 64'h0, 4'd3);
        chk("sim_count2", 64'(fifo_count), 64'h2);
        step();
        chk("sim_a_valid", 64'(rsp_valid), 64'h1);
        chk("sim_a_data", rsp_data, 64'h11);
        rsp_ready = 1'b1;
        step();
        chk("sim_idle_count", 64'(fifo_count), 64'h2);
        push(3'b010, 64'h1234, 64'h0, 4'd4);
        chk("sim_pushpop_count", 64'(fifo_count), 64'h2);
        expect_rsp("sim_b", 2, 64'hFFFFFFFFFFFFFF0F, 4'd2, 1'b0);
        expect_rsp("sim_c", 3, 64'hFFFFFFFFFFFFFF00, 4'd3, 1'b0);
        expect_rsp("sim_d", 3, 64'h1234, 4'd4, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        push(3'b000, 64'h3, 64'h1, 4'd1);
        push(3'b010, 64'h4, 64'h1, 4'd2);
        push(3'b100, 64'h5, 64'h1, 4'd3);
        chk("r4_count", 64'(fifo_count4), 64'h2);
        chk("r4_busy", 64'(busy4), 64'h1);
        step();
        chk("r4_wait_valid", 64'(rsp_valid4), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("r4_cmd_ready", 64'(cmd_ready4), 64'h1);
        chk("r4_count0", 64'(fifo_count4), 64'h0);
        chk("r4_busy0", 64'(busy4), 64'h0);
        chk("r4_valid0", 64'(rsp_valid4), 64'h0);
        chk("r4_log_op", 64'(log_op4), 64'h0);
        chk("r4_log_opa", log_opa4, 64'h0);
        chk("r4_log_opb", log_opb4, 64'h0);
        chk("r4_rsp_data", rsp_data4, 64'h0);
        chk("r4_rsp_tag", 64'(rsp_tag4), 64'h0);
        chk("r4_rsp_err", 64'(rsp_err4), 64'h0);
        step();
        rst_n = 1'b1;
        watch = 1'b1;
        repeat (20) step();
        chk("r4_no_rsp", 64'(seen4), 64'h0);
        chk("r4_idle", 64'(busy4), 64'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
